// File: rtl/coco_fdc_hub.sv
// coco_fdc_hub
//   Host front-end for 1..4 external wd1793 controllers, one per SD-block drive.
//   Holds the $FF40 drive-control register, decodes drive/side selects,
//   stretches CPU accesses to $FF48-$FF4B onto the divided FDC clock enable,
//   keeps per-drive mount status and folds DRQ/INTRQ into HALT and NMI.
//
// Ports
//   CLK, RESET_N              clock, async active-low reset
//   ADDRESS, DATA_IN          CPU address [3:0] and write data
//   FF40_WR                   one-cycle write strobe for $FF40
//   FDC_RD_REQ, FDC_WR_REQ    level requests for $FF48-$FF4B, masked by DISABLE
//   FDC_CE                    clock enable shared by all wd1793 instances
//   FDC_RD, FDC_WR            per-drive access strobes
//   FDC_ADDR, FDC_DIN         register address / write data latched per access
//   FDC_DOUT, FDC_DRQ,
//   FDC_INTRQ                 per-drive wd1793 outputs
//   img_mounted, img_readonly,
//   img_size                  SD-block mount notification
//   drive_wp, drive_ready,
//   double_sided              per-drive mount status (survives core reset)
//   SIDE                      side select for the wd1793s
//   DATA_OUT                  CPU read data
//   HALT, NMI_09              CPU halt / NMI
//   HALT_TIMEOUT              sticky: HALT watchdog expired
//
// Access sequencer
//   state    | meaning
//   ACC_IDLE | no access in flight, waiting for a request edge
//   ACC_BUSY | strobe held, waiting for the next FDC_CE to retire it
module coco_fdc_hub #(
   parameter int NUM_DRIVES     = 4,
   parameter int CE_DIV         = 6,
   parameter bit SIDE_SELECT    = 1'b1,
   parameter int HALT_TO_CYCLES = 1000000
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   input  logic [3:0]                ADDRESS,
   input  logic [7:0]                DATA_IN,
   input  logic                      FF40_WR,
   input  logic                      FDC_RD_REQ,
   input  logic                      FDC_WR_REQ,
   input  logic                      DISABLE,
   output logic                      FDC_CE,
   output logic [NUM_DRIVES-1:0]     FDC_RD,
   output logic [NUM_DRIVES-1:0]     FDC_WR,
   output logic [1:0]                FDC_ADDR,
   output logic [7:0]                FDC_DIN,
   input  logic [8*NUM_DRIVES-1:0]   FDC_DOUT,
   input  logic [NUM_DRIVES-1:0]     FDC_DRQ,
   input  logic [NUM_DRIVES-1:0]     FDC_INTRQ,
   input  logic [NUM_DRIVES-1:0]     img_mounted,
   input  logic                      img_readonly,
   input  logic [63:0]               img_size,
   output logic [NUM_DRIVES-1:0]     drive_wp,
   output logic [NUM_DRIVES-1:0]     drive_ready,
   output logic [NUM_DRIVES-1:0]     double_sided,
   output logic                      SIDE,
   output logic [7:0]                DATA_OUT,
   output logic                      HALT,
   output logic                      NMI_09,
   output logic                      HALT_TIMEOUT
);

   localparam int CE_W = $clog2(CE_DIV);
   localparam int WD_W = (HALT_TO_CYCLES > 2) ? $clog2(HALT_TO_CYCLES) : 1;

   typedef enum logic {ACC_IDLE, ACC_BUSY} acc_state_t;
   acc_state_t acc_state, acc_next;

   logic [CE_W-1:0]        ce_cnt;
   logic                   halt_en, density, precomp, motor;
   logic [3:0]             sel;
   logic [1:0]             drive_index, idx_next;
   logic                   idx_hit;
   logic [3:0]             idx_cand;
   logic                   rd_s1, rd_s2, rd_s3, wr_s1, wr_s2, wr_s3;
   logic                   rd_edge, wr_edge;
   logic                   acc_start, acc_done;
   logic [3:0]             rd_strobe, wr_strobe;
   logic [3:0]             drq_pad, intrq_pad, ds_pad;
   logic [31:0]            dout_pad;
   logic                   sel_drq, sel_intrq;
   logic [WD_W-1:0]        wd_cnt;
   logic                   wd_fire;
   logic                   img_ds;
   logic                   unused_addr;

   // Mount status has no reset: it must outlive a core reset. Power-up values only.
   logic [NUM_DRIVES-1:0]  mnt_d = '0;
   logic [NUM_DRIVES-1:0]  wp_q  = '1;
   logic [NUM_DRIVES-1:0]  rdy_q = '0;
   logic [NUM_DRIVES-1:0]  ds_q  = '0;

   assign unused_addr = ADDRESS[2];

   assign FDC_CE = (ce_cnt == CE_W'(CE_DIV - 1));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)    ce_cnt <= '0;
      else if (FDC_CE) ce_cnt <= '0;
      else             ce_cnt <= ce_cnt + CE_W'(1);
   end

   // Zero-extend per-drive vectors to four so the selected drive can be indexed directly.
   always_comb begin
      drq_pad   = '0;
      intrq_pad = '0;
      ds_pad    = '0;
      dout_pad  = '0;
      drq_pad[NUM_DRIVES-1:0]     = FDC_DRQ;
      intrq_pad[NUM_DRIVES-1:0]   = FDC_INTRQ;
      ds_pad[NUM_DRIVES-1:0]      = ds_q;
      dout_pad[8*NUM_DRIVES-1:0]  = FDC_DOUT;
   end

   assign sel_drq   = drq_pad[drive_index];
   assign sel_intrq = intrq_pad[drive_index];

   // D6 is a fourth drive select only in the four-drive, no-side-select build.
   always_comb begin
      idx_cand = {(!SIDE_SELECT && NUM_DRIVES == 4) & DATA_IN[6], DATA_IN[2:0]};
      idx_next = drive_index;
      idx_hit  = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (idx_cand[i] && i < NUM_DRIVES) begin
            idx_next = 2'(i);
            idx_hit  = 1'b1;
         end
      end
   end

   assign wd_fire = (HALT_TO_CYCLES != 0) && HALT &&
                    (wd_cnt == WD_W'(HALT_TO_CYCLES - 1));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         halt_en     <= 1'b0;
         density     <= 1'b0;
         precomp     <= 1'b0;
         motor       <= 1'b0;
         sel         <= '0;
         drive_index <= '0;
      end else begin
         if (FF40_WR) begin
            halt_en <= DATA_IN[7];
            density <= DATA_IN[5];
            precomp <= DATA_IN[4];
            motor   <= DATA_IN[3];
            sel     <= {DATA_IN[6], DATA_IN[2:0]};
            if (idx_hit) drive_index <= idx_next;
         end
         // Controller interrupt or watchdog expiry releases the CPU even over a concurrent write.
         if (sel_intrq || wd_fire) halt_en <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wd_cnt       <= '0;
         HALT_TIMEOUT <= 1'b0;
      end else begin
         if (FF40_WR || !HALT || wd_fire) wd_cnt <= '0;
         else if (HALT_TO_CYCLES != 0)     wd_cnt <= wd_cnt + WD_W'(1);
         if (wd_fire) HALT_TIMEOUT <= 1'b1;
         if (FF40_WR) HALT_TIMEOUT <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         {rd_s1, rd_s2, rd_s3} <= '0;
         {wr_s1, wr_s2, wr_s3} <= '0;
         FDC_ADDR <= '0;
         FDC_DIN  <= '0;
      end else begin
         rd_s1 <= FDC_RD_REQ & ~DISABLE;
         rd_s2 <= rd_s1;
         rd_s3 <= rd_s2;
         wr_s1 <= FDC_WR_REQ & ~DISABLE;
         wr_s2 <= wr_s1;
         wr_s3 <= wr_s2;
         if ((rd_s1 & ~rd_s2) | (wr_s1 & ~wr_s2)) begin
            FDC_ADDR <= ADDRESS[1:0];
            FDC_DIN  <= DATA_IN;
         end
      end
   end

   assign rd_edge = rd_s2 & ~rd_s3;
   assign wr_edge = wr_s2 & ~wr_s3;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) acc_state <= ACC_IDLE;
      else          acc_state <= acc_next;
   end

   always_comb begin
      acc_next  = acc_state;
      acc_start = 1'b0;
      acc_done  = 1'b0;
      case (acc_state)
         ACC_IDLE: if (rd_edge || wr_edge) begin
            acc_next  = ACC_BUSY;
            acc_start = 1'b1;
         end
         ACC_BUSY: if (FDC_CE) begin
            acc_next = ACC_IDLE;
            acc_done = 1'b1;
         end
         default: acc_next = ACC_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rd_strobe <= '0;
         wr_strobe <= '0;
      end else if (acc_start) begin
         if (wr_edge) wr_strobe[drive_index] <= 1'b1;
         else         rd_strobe[drive_index] <= 1'b1;
      end else if (acc_done) begin
         rd_strobe <= '0;
         wr_strobe <= '0;
      end
   end

   // The early read term is suppressed while a write is in the pipe so a
   // colliding read never reaches the controller.
   always_comb begin
      FDC_RD = '0;
      FDC_WR = '0;
      for (int i = 0; i < NUM_DRIVES; i++) begin
         FDC_RD[i] = ((rd_s2 & ~wr_s2) | rd_strobe[i]) & (drive_index == 2'(i));
         FDC_WR[i] = (wr_s2 | wr_strobe[i]) & (drive_index == 2'(i));
      end
   end

   assign HALT     = halt_en & ~sel_drq;
   assign NMI_09   = density & sel_intrq;
   assign SIDE     = SIDE_SELECT & sel[3] & ds_pad[drive_index];
   assign DATA_OUT = ADDRESS[3] ? dout_pad[{drive_index, 3'b000} +: 8]
                                : {halt_en, sel[3], density, precomp, motor, sel[2:0]};

   assign img_ds = (img_size > 64'd368600) && (img_size < 64'd740000);

   always_ff @(posedge CLK) begin
      mnt_d <= img_mounted;
      for (int i = 0; i < NUM_DRIVES; i++) begin
         if (mnt_d[i] & ~img_mounted[i]) begin
            wp_q[i]  <= img_readonly;
            rdy_q[i] <= 1'b1;
            ds_q[i]  <= img_ds;
         end
      end
   end

   assign drive_wp     = wp_q;
   assign drive_ready  = rdy_q;
   assign double_sided = ds_q;

endmodule

// File: tb/tb_coco_fdc_hub.sv
module tb_coco_fdc_hub;
   localparam int ND = 4;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic [3:0]    ADDRESS = '0;
   logic [7:0]    DATA_IN = '0;
   logic          FF40_WR = 1'b0;
   logic          FDC_RD_REQ = 1'b0;
   logic          FDC_WR_REQ = 1'b0;
   logic          DISABLE = 1'b0;
   logic          FDC_CE;
   logic [ND-1:0] FDC_RD, FDC_WR;
   logic [1:0]    FDC_ADDR;
   logic [7:0]    FDC_DIN;
   logic [31:0]   FDC_DOUT = 32'h44332211;
   logic [ND-1:0] FDC_DRQ = 4'hF;
   logic [ND-1:0] FDC_INTRQ = '0;
   logic [ND-1:0] img_mounted = '0;
   logic          img_readonly = 1'b0;
   logic [63:0]   img_size = '0;
   logic [ND-1:0] drive_wp, drive_ready, double_sided;
   logic          SIDE, HALT, NMI_09, HALT_TIMEOUT;
   logic [7:0]    DATA_OUT;

   coco_fdc_hub #(.NUM_DRIVES(ND), .CE_DIV(6), .SIDE_SELECT(1'b1), .HALT_TO_CYCLES(100)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN), .FF40_WR(FF40_WR),
      .FDC_RD_REQ(FDC_RD_REQ), .FDC_WR_REQ(FDC_WR_REQ), .DISABLE(DISABLE), .FDC_CE(FDC_CE),
      .FDC_RD(FDC_RD), .FDC_WR(FDC_WR), .FDC_ADDR(FDC_ADDR), .FDC_DIN(FDC_DIN),
      .FDC_DOUT(FDC_DOUT), .FDC_DRQ(FDC_DRQ), .FDC_INTRQ(FDC_INTRQ),
      .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
      .drive_wp(drive_wp), .drive_ready(drive_ready), .double_sided(double_sided),
      .SIDE(SIDE), .DATA_OUT(DATA_OUT), .HALT(HALT), .NMI_09(NMI_09), .HALT_TIMEOUT(HALT_TIMEOUT)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int            m_idx = 0;
   logic [3:0]    m_wp = 4'hF, m_rdy = 4'h0, m_ds = 4'h0;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] exp_ctrl;
      logic [7:0] exp_dout;
      logic       exp_side;
   } vec_t;
   vec_t vt[8];

   bit         found, fin, drop_ce;
   int         n;
   logic [3:0] rd_seen, wr_seen;
   logic [7:0] rd_d, rd_data;
   logic [3:0] rd_addr;
   logic [31:0] dv;
   bit         is_wr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic int model_idx(input logic [7:0] d, input int cur);
      if (d[0]) return 0;
      if (d[1]) return 1;
      if (d[2]) return 2;
      return cur;
   endfunction

   function automatic bit model_ds(input logic [63:0] s);
      return (s > 64'd368600) && (s < 64'd740000);
   endfunction

   task automatic ff40(input logic [7:0] d);
      DATA_IN = d;
      FF40_WR = 1'b1;
      tick();
      FF40_WR = 1'b0;
      m_idx = model_idx(d, m_idx);
   endtask

   task automatic mount(input int drv, input logic [63:0] size, input logic ro);
      img_size = size;
      img_readonly = ro;
      img_mounted = 4'(1 << drv);
      tick();
      img_mounted = '0;
      tick();
      tick();
      img_size = '0;
      img_readonly = ~ro;
      m_wp[drv] = ro;
      m_rdy[drv] = 1'b1;
      m_ds[drv] = model_ds(size);
   endtask

   task automatic do_access(input bit rd, input bit wr, input logic [3:0] addr, input logic [7:0] data,
                            output logic [3:0] rs, output logic [3:0] ws,
                            output bit dropped_after_ce, output bit finished);
      bit was_high, prev_ce;
      ADDRESS = addr;
      DATA_IN = data;
      FDC_RD_REQ = rd;
      FDC_WR_REQ = wr;
      rs = '0; ws = '0; dropped_after_ce = 1'b0; finished = 1'b0;
      was_high = 1'b0; prev_ce = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k == 1) begin
            FDC_RD_REQ = 1'b0;
            FDC_WR_REQ = 1'b0;
         end
         rs |= FDC_RD;
         ws |= FDC_WR;
         if ((FDC_RD | FDC_WR) != 0) begin
            was_high = 1'b1;
            prev_ce = FDC_CE;
         end else if (was_high) begin
            dropped_after_ce = prev_ce;
            finished = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vt[0] = '{8'h00, 8'h00, 8'h11, 1'b0};
      vt[1] = '{8'h02, 8'h02, 8'h22, 1'b0};
      vt[2] = '{8'h40, 8'h40, 8'h22, 1'b0};
      vt[3] = '{8'h04, 8'h04, 8'h33, 1'b0};
      vt[4] = '{8'h06, 8'h06, 8'h22, 1'b0};
      vt[5] = '{8'h07, 8'h07, 8'h11, 1'b0};
      vt[6] = '{8'h44, 8'h44, 8'h33, 1'b0};
      vt[7] = '{8'h08, 8'h08, 8'h33, 1'b0};

      // reset and power-up state
      repeat (3) tick();
      check("rst_data_out", DATA_OUT, 8'h00);
      RESET_N = 1'b1;
      tick();
      check("rst_fdc_rd", FDC_RD, 4'h0);
      check("rst_fdc_wr", FDC_WR, 4'h0);
      check("rst_fdc_addr", FDC_ADDR, 2'd0);
      check("rst_fdc_din", FDC_DIN, 8'h00);
      check("rst_halt", HALT, 1'b0);
      check("rst_timeout", HALT_TIMEOUT, 1'b0);
      check("pwr_wp", drive_wp, 4'hF);
      check("pwr_ready", drive_ready, 4'h0);
      check("pwr_ds", double_sided, 4'h0);

      // CE period
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (FDC_CE) begin found = 1'b1; break; end
         tick();
      end
      check("ce_found", found, 1'b1);
      for (int r = 0; r < 2; r++) begin
         n = 0;
         do begin tick(); n++; end while (!FDC_CE && n < 20);
         check("ce_period", n, 6);
      end

      // table: control register writes, readback and drive decode
      for (int i = 0; i < 8; i++) begin
         ff40(vt[i].d);
         ADDRESS = 4'h0; #1;
         check($sformatf("tbl%0d_ctrl", i), DATA_OUT, vt[i].exp_ctrl);
         ADDRESS = 4'h8; #1;
         check($sformatf("tbl%0d_dout", i), DATA_OUT, vt[i].exp_dout);
         check($sformatf("tbl%0d_side", i), SIDE, vt[i].exp_side);
      end

      // write access timing on drive 0
      ff40(8'hA9);
      ADDRESS = 4'hB; DATA_IN = 8'h5A; FDC_WR_REQ = 1'b1;
      tick();
      check("wr_not_yet", FDC_WR, 4'h0);
      tick();
      check("wr_at_2clk", FDC_WR, 4'b0001);
      check("wr_addr", FDC_ADDR, 2'd3);
      check("wr_din", FDC_DIN, 8'h5A);
      FDC_WR_REQ = 1'b0; DATA_IN = 8'h00;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (FDC_CE) begin
            check("wr_through_ce", FDC_WR, 4'b0001);
            tick();
            check("wr_drop_after_ce", FDC_WR, 4'h0);
            found = 1'b1;
            break;
         end
      end
      if (!found) check("wr_ce_timeout", 1'b0, 1'b1);
      check("wr_din_held", FDC_DIN, 8'h5A);

      // HALT / DRQ / INTRQ on drive 1
      ff40(8'h82);
      FDC_DRQ = 4'h0; #1;
      check("halt_on", HALT, 1'b1);
      FDC_DRQ[1] = 1'b1; #1;
      check("halt_drq", HALT, 1'b0);
      FDC_INTRQ[1] = 1'b1; #1;
      check("nmi_no_density", NMI_09, 1'b0);
      tick();
      FDC_INTRQ = '0; FDC_DRQ = 4'h0; ADDRESS = 4'h0; #1;
      check("halt_en_cleared", HALT, 1'b0);
      check("ctrl_after_intrq", DATA_OUT, 8'h02);

      // NMI gating
      ff40(8'h21);
      FDC_INTRQ = 4'b0001; #1;
      check("nmi_sel", NMI_09, 1'b1);
      FDC_INTRQ = 4'b0100; #1;
      check("nmi_unsel", NMI_09, 1'b0);
      FDC_INTRQ = '0;

      // HALT watchdog
      ff40(8'h80);
      n = 0;
      while (HALT && n < 200) begin tick(); n++; end
      check("wd_halt_cycles", n, 100);
      check("wd_timeout_set", HALT_TIMEOUT, 1'b1);
      check("wd_halt_dropped", HALT, 1'b0);
      ff40(8'h00);
      check("wd_timeout_clear", HALT_TIMEOUT, 1'b0);
      FDC_DRQ = 4'hF;

      // mounts, including size boundaries
      mount(2, 64'd368640, 1'b1);
      check("mnt2_wp", drive_wp, m_wp);
      check("mnt2_ready", drive_ready, m_rdy);
      check("mnt2_ds", double_sided, m_ds);
      mount(1, 64'd1000000, 1'b0);
      mount(0, 64'd368600, 1'b0);
      mount(3, 64'd739999, 1'b1);
      check("mnt_all_wp", drive_wp, m_wp);
      check("mnt_all_ready", drive_ready, m_rdy);
      check("mnt_all_ds", double_sided, m_ds);

      // mount status survives reset
      RESET_N = 1'b0;
      repeat (3) tick();
      check("persist_wp", drive_wp, m_wp);
      check("persist_ready", drive_ready, m_rdy);
      check("persist_ds", double_sided, m_ds);
      RESET_N = 1'b1;
      m_idx = 0;
      tick();
      ADDRESS = 4'h0; #1;
      check("post_rst_ctrl", DATA_OUT, 8'h00);

      // side select gated by double_sided
      ff40(8'h44); #1;
      check("side_ds", SIDE, m_ds[m_idx]);
      ff40(8'h42); #1;
      check("side_ss", SIDE, m_ds[m_idx]);

      // DISABLE masks requests
      DISABLE = 1'b1;
      do_access(1'b1, 1'b0, 4'h8, 8'h00, rd_seen, wr_seen, drop_ce, fin);
      check("dis_rd", rd_seen, 4'h0);
      check("dis_wr", wr_seen, 4'h0);
      DISABLE = 1'b0;

      // colliding read and write: write wins
      do_access(1'b1, 1'b1, 4'h9, 8'h3C, rd_seen, wr_seen, drop_ce, fin);
      check("coll_rd", rd_seen, 4'h0);
      check("coll_wr", wr_seen, 4'(1 << m_idx));
      check("coll_done", fin, 1'b1);

      // randomized
      for (int it = 0; it < 20; it++) begin
         rd_d = 8'($urandom);
         FDC_DOUT = $urandom;
         ff40(rd_d);
         dv = FDC_DOUT;
         ADDRESS = {2'b10, 2'($urandom)}; #1;
         check("rnd_dout", DATA_OUT, dv[m_idx*8 +: 8]);
         ADDRESS = 4'h0; #1;
         check("rnd_ctrl", DATA_OUT, rd_d);
         check("rnd_side", SIDE, rd_d[6] & m_ds[m_idx]);
         repeat ($urandom_range(0, 5)) tick();
         is_wr = 1'($urandom_range(0, 1));
         rd_addr = {1'b1, 3'($urandom)};
         rd_data = 8'($urandom);
         do_access(~is_wr, is_wr, rd_addr, rd_data, rd_seen, wr_seen, drop_ce, fin);
         check("rnd_done", fin, 1'b1);
         check("rnd_rd", rd_seen, is_wr ? 4'h0 : 4'(1 << m_idx));
         check("rnd_wr", wr_seen, is_wr ? 4'(1 << m_idx) : 4'h0);
         check("rnd_drop_ce", drop_ce, 1'b1);
         check("rnd_addr", FDC_ADDR, rd_addr[1:0]);
         check("rnd_din", FDC_DIN, rd_data);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
